// File: rtl/line_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : line_dispatcher
// Function : Round-robin row dispatcher into a 3-deep line-buffer bank, with
//            top/bottom zero-padding rows when LINE_DISPATCH_PAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module line_dispatcher #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int PADDING   = 1,
    parameter int NUM_LINES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [2:0]  m_valid,
    input  logic [2:0]  m_ready,
    output logic [2:0]  use_as_padding,
    output logic [2:0]  line_clr,
    input  logic        row_release,
    output logic [1:0]  rd_base,
    output logic        busy,
    output logic        frame_done
);

`ifdef LINE_DISPATCH_PAD_EN
    localparam int c_pad = PADDING;
`else
    localparam int c_pad = PADDING * 0;
`endif
    localparam int c_loads = HEIGHT + 2 * c_pad;
    localparam int c_wins  = c_loads - 2;
    localparam int c_col_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_ld_w  = $clog2(c_loads + 1);
    localparam int c_win_w = (c_wins > 1) ? $clog2(c_wins) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAD   = 3'd1,
        ST_FILL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_col_w-1:0] r_col;
    logic [c_ld_w-1:0]  r_ld_cnt;
    logic [c_win_w-1:0] r_win_cnt;
    logic [1:0]         r_wr_sel;
    logic [2:0]         r_occ;
`ifdef LINE_DISPATCH_PAD_EN
    logic [2:0]         r_pad;
`endif

    logic [2:0]         w_wr_onehot;
    logic [2:0]         w_rd_onehot;
    logic [c_ld_w-1:0]  w_ld_next;
    logic               w_accept;
    logic               w_last_pix;
    logic               w_full_next;
    state_t             w_load_now;
    state_t             w_load_next;

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return (sel == 2'(NUM_LINES - 1)) ? 2'd0 : sel + 2'd1;
    endfunction

    assign w_wr_onehot = 3'b001 << r_wr_sel;
    assign w_rd_onehot = 3'b001 << rd_base;
    assign w_ld_next   = r_ld_cnt + 1'b1;
    assign w_full_next = &(r_occ | w_wr_onehot);
    assign w_accept    = s_valid & s_ready;
    assign w_last_pix  = (r_col == c_col_w'(WIDTH - 1));

    // Load type for the row about to be loaded (now) or the one after (next)
    always_comb begin
`ifdef LINE_DISPATCH_PAD_EN
        w_load_now  = (int'(r_ld_cnt) < c_pad || int'(r_ld_cnt) >= c_pad + HEIGHT)
                      ? ST_PAD : ST_FILL;
        w_load_next = (int'(w_ld_next) < c_pad || int'(w_ld_next) >= c_pad + HEIGHT)
                      ? ST_PAD : ST_FILL;
`else
        w_load_now  = ST_FILL;
        w_load_next = ST_FILL;
`endif
    end

    assign s_ready = (r_state == ST_FILL) & m_ready[r_wr_sel];
    assign m_valid = (r_state == ST_FILL && s_valid) ? w_wr_onehot : 3'b000;
    assign m_data  = s_data;
    assign busy    = (r_state != ST_IDLE);
`ifdef LINE_DISPATCH_PAD_EN
    assign use_as_padding = r_pad;
`else
    assign use_as_padding = 3'b000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_ld_cnt   <= '0;
            r_win_cnt  <= '0;
            r_wr_sel   <= '0;
            rd_base    <= '0;
            r_occ      <= '0;
            line_clr   <= '0;
            frame_done <= 1'b0;
`ifdef LINE_DISPATCH_PAD_EN
            r_pad      <= '0;
`endif
        end else begin
            line_clr   <= '0;
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) r_state <= w_load_now;
                end
`ifdef LINE_DISPATCH_PAD_EN
                ST_PAD: begin
                    r_pad    <= r_pad | w_wr_onehot;
                    r_occ    <= r_occ | w_wr_onehot;
                    r_ld_cnt <= w_ld_next;
                    r_wr_sel <= next_sel(r_wr_sel);
                    r_state  <= w_full_next ? ST_WAIT : w_load_next;
                end
`endif
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_last_pix) begin
                            r_col    <= '0;
                            r_occ    <= r_occ | w_wr_onehot;
                            r_ld_cnt <= w_ld_next;
                            r_wr_sel <= next_sel(r_wr_sel);
                            r_state  <= w_full_next ? ST_WAIT : w_load_next;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // line_clr/frame_done are registered so they coincide with CLEAR/FLUSH
                    if (row_release) begin
                        if (r_win_cnt == c_win_w'(c_wins - 1)) begin
                            r_state    <= ST_FLUSH;
                            line_clr   <= 3'b111;
                            frame_done <= 1'b1;
                        end else begin
                            r_win_cnt <= r_win_cnt + 1'b1;
                            line_clr  <= w_rd_onehot;
                            r_state   <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_occ   <= r_occ & ~w_rd_onehot;
`ifdef LINE_DISPATCH_PAD_EN
                    r_pad   <= r_pad & ~w_rd_onehot;
`endif
                    rd_base <= next_sel(rd_base);
                    r_state <= w_load_now;
                end
                ST_FLUSH: begin
                    r_occ     <= '0;
`ifdef LINE_DISPATCH_PAD_EN
                    r_pad     <= '0;
`endif
                    r_ld_cnt  <= '0;
                    r_win_cnt <= '0;
                    r_wr_sel  <= '0;
                    rd_base   <= '0;
                    r_col     <= '0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
